// File: rtl/qpp_deinterleaver.sv
// QPP deinterleaver for LTE turbo blocks (K = 1056 or K = 6144).
// Incoming byte i is written to buffer address pi(i) = (f1*i + f2*i^2) mod K.
// pi is stepped with adders only: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*f2.
// Once the block is stored, the buffer is read out sequentially 0..K-1.
module qpp_deinterleaver (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       CRC_start,
  input  logic       CRC_blocksize,
  input  logic       CRC_end,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       done,
  output logic       error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] READ   = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam int K_S  = 1056;
  localparam int F1_S = 17;
  localparam int F2_S = 66;
  localparam int K_L  = 6144;
  localparam int F1_L = 263;
  localparam int F2_L = 480;

  // Recurrence state for byte 1 is loaded directly on CRC_start:
  // pi(1) = g(0) = f1 + f2, g(1) = f1 + 3*f2, step of g = 2*f2 (all mod K).
  localparam logic [12:0] K_SMALL   = 13'(K_S);
  localparam logic [12:0] K_LARGE   = 13'(K_L);
  localparam logic [12:0] PI1_SMALL = 13'((F1_S + F2_S) % K_S);
  localparam logic [12:0] PI1_LARGE = 13'((F1_L + F2_L) % K_L);
  localparam logic [12:0] G1_SMALL  = 13'((F1_S + 3 * F2_S) % K_S);
  localparam logic [12:0] G1_LARGE  = 13'((F1_L + 3 * F2_L) % K_L);
  localparam logic [12:0] DG_SMALL  = 13'((2 * F2_S) % K_S);
  localparam logic [12:0] DG_LARGE  = 13'((2 * F2_L) % K_L);

  logic [1:0]  state;
  logic        blk_large;
  logic [12:0] idx;
  logic [12:0] pi_r;
  logic [12:0] g_r;
  logic [12:0] rd_addr;
  logic        rd_valid;
  logic        err_pend;
  logic [7:0]  rd_data;

  logic [7:0]  mem [0:6143];

  logic [12:0] k_val;
  logic [12:0] k_last;
  logic [12:0] dg;
  logic [12:0] pi_next;
  logic [12:0] g_next;
  logic        mem_we;
  logic [12:0] mem_wa;

  // Addition of two residues followed by one conditional subtract of K.
  function automatic logic [12:0] mod_add(input logic [12:0] a,
                                          input logic [12:0] b,
                                          input logic [12:0] k);
    logic [13:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, k}) s = s - {1'b0, k};
    return s[12:0];
  endfunction

  // Block-size dependent constants, next recurrence values and buffer write port.
  always_comb begin
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    k_val   = blk_large ? K_LARGE : K_SMALL;
    k_last  = k_val - 13'd1;
    dg      = blk_large ? DG_LARGE : DG_SMALL;
    pi_next = mod_add(pi_r, g_r, k_val);
    g_next  = mod_add(g_r, dg, k_val);
    mem_we  = (state == LOAD) || ((state == IDLE) && CRC_start);
    mem_wa  = (state == LOAD) ? pi_r : 13'd0;
  end

  // Block buffer: one scattered write and one sequential synchronous read per cycle.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; every location read is written earlier in the same block.
    if (mem_we) mem[mem_wa] <= data_in;
    rd_data <= mem[rd_addr];
  end

  // Control FSM, recurrence registers and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      blk_large  <= 1'b0;
      idx        <= 13'd0;
      pi_r       <= 13'd0;
      g_r        <= 13'd0;
      rd_addr    <= 13'd0;
      rd_valid   <= 1'b0;
      err_pend   <= 1'b0;
      data_out   <= 8'h00;
      data_ready <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      done       <= 1'b0;
      error      <= err_pend;
      err_pend   <= 1'b0;
      rd_valid   <= (state == READ);
      data_ready <= rd_valid;
      data_out   <= rd_valid ? rd_data : 8'h00;

      case (state)
        IDLE: begin
          if (CRC_start) begin
            if (CRC_end) begin
              // A one-byte block is never legal.
              error <= 1'b1;
            end else begin
              blk_large <= CRC_blocksize;
              idx       <= 13'd1;
              pi_r      <= CRC_blocksize ? PI1_LARGE : PI1_SMALL;
              g_r       <= CRC_blocksize ? G1_LARGE : G1_SMALL;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          pi_r <= pi_next;
          g_r  <= g_next;
          idx  <= idx + 13'd1;
          if (CRC_end && (idx == k_last)) begin
            rd_addr <= 13'd0;
            state   <= READ;
          end else if (CRC_end || (idx == k_last)) begin
            // Length violation: drop the block, report on the following cycle.
            err_pend <= 1'b1;
            idx      <= 13'd0;
            state    <= IDLE;
          end
        end
        READ: begin
          rd_addr <= rd_addr + 13'd1;
          if (rd_addr == k_last) state <= FINISH;
        end
        FINISH: begin
          // Wait until the last byte has left the output register.
          if (!rd_valid) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpp_deinterleaver.sv
// Randomized bench for qpp_deinterleaver with a permutation reference model.
module tb_qpp_deinterleaver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       CRC_start;
  logic       CRC_blocksize;
  logic       CRC_end;
  logic [7:0] data_out;
  logic       data_ready;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  logic [7:0] src     [0:6143];
  logic [7:0] din     [0:6143];
  logic [7:0] exp_out [0:6143];

  always #5 clk = ~clk;

  qpp_deinterleaver dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .CRC_start     (CRC_start),
    .CRC_blocksize (CRC_blocksize),
    .CRC_end       (CRC_end),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .done          (done),
    .error         (error)
  );

  // Observed output word: {data_ready, done, error, data_out}.
  function automatic logic [10:0] status();
    return {data_ready, done, error, data_out};
  endfunction

  task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // QPP permutation evaluated directly from its closed form.
  function automatic int pi_of(input int k, input int i);
    longint f1, f2, v;
    f1 = (k == 1056) ? 17 : 263;
    f2 = (k == 1056) ? 66 : 480;
    v  = (f1 * i + f2 * i * i) % k;
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    CRC_start = 1'b0;
    CRC_end   = 1'b0;
    data_in   = 8'($urandom);
  endtask

  // mode 0: din[i] = i mod 256, out[pi(i)] = din[i].
  // mode 1: loopback, din = interleaved random source, out = source.
  task automatic run_block(input int k, input int mode, input int load_start_at,
                           input int read_start_at, input int stop_pos);
    logic        bs;
    logic [10:0] exp;
    bs = (k == 6144);
    for (int i = 0; i < k; i++) src[i] = 8'($urandom);
    for (int i = 0; i < k; i++) begin
      if (mode == 0) begin
        din[i] = 8'(i);
        exp_out[pi_of(k, i)] = 8'(i);
      end else begin
        din[i] = src[pi_of(k, i)];
      end
    end
    if (mode != 0)
      for (int j = 0; j < k; j++) exp_out[j] = src[j];

    for (int i = 0; i < k; i++) begin
      data_in       = din[i];
      CRC_start     = (i == 0) || (i == load_start_at);
      CRC_blocksize = (i == 0) ? bs : ~bs;
      CRC_end       = (i == k - 1);
      tick();
      check($sformatf("load k=%0d i=%0d", k, i), status(), 11'h000);
    end

    for (int c = 1; c <= k + 2; c++) begin
      idle_inputs();
      CRC_start     = (c == read_start_at);
      CRC_blocksize = ~bs;
      tick();
      if (c == 1)          exp = 11'h000;
      else if (c <= k + 1) exp = {3'b100, exp_out[c - 2]};
      else                 exp = 11'h200;
      check($sformatf("out k=%0d c=%0d", k, c), status(), exp);
      if ((stop_pos >= 0) && (c - 2 == stop_pos)) break;
    end
    idle_inputs();
  endtask

  // Block with a length violation; end_at < 0 means CRC_end never comes.
  task automatic abort_block(input int k, input int end_at);
    int n;
    n = (end_at < 0) ? k : end_at + 1;
    for (int i = 0; i < n; i++) begin
      data_in       = 8'($urandom);
      CRC_start     = (i == 0);
      CRC_blocksize = (k == 6144);
      CRC_end       = (i == end_at);
      tick();
      check($sformatf("abort load k=%0d i=%0d", k, i), status(), 11'h000);
    end
    for (int c = 1; c <= 20; c++) begin
      idle_inputs();
      tick();
      check($sformatf("abort tail k=%0d c=%0d", k, c), status(),
            (c == 1) ? 11'h100 : 11'h000);
    end
  endtask

  task automatic apply_reset(input string tag);
    idle_inputs();
    reset = 1'b1;
    tick();
    check({tag, " in reset"}, status(), 11'h000);
    reset = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("%s after reset c=%0d", tag, c), status(), 11'h000);
    end
  endtask

  initial begin
    reset         = 1'b1;
    data_in       = 8'h00;
    CRC_start     = 1'b0;
    CRC_blocksize = 1'b0;
    CRC_end       = 1'b0;
    tick();
    tick();
    apply_reset("power-on");

    // Counting pattern, both sizes, back to back (second start at N+K+3).
    run_block(1056, 0, -1, -1, -1);
    run_block(6144, 0, -1, -1, -1);

    // Loopback with random source for both sizes.
    run_block(1056, 1, -1, -1, -1);
    run_block(6144, 1, -1, -1, -1);

    // Early CRC_end, then a good block.
    abort_block(1056, 500);
    run_block(1056, 0, -1, -1, -1);

    // Missing CRC_end, then a good block.
    abort_block(1056, -1);
    run_block(6144, 1, -1, -1, -1);

    // CRC_start and CRC_end together in IDLE.
    data_in       = 8'($urandom);
    CRC_start     = 1'b1;
    CRC_end       = 1'b1;
    CRC_blocksize = 1'b0;
    tick();
    check("start+end error", status(), 11'h100);
    for (int c = 1; c <= 4; c++) begin
      idle_inputs();
      tick();
      check($sformatf("start+end tail c=%0d", c), status(), 11'h000);
    end

    // Stray CRC_start during LOAD and READ is ignored.
    run_block(1056, 1, 300, 400, -1);
    run_block(6144, 1, 1234, 5000, -1);

    // Reset while output position 300 is on data_out, then a fresh block.
    run_block(1056, 0, -1, -1, 300);
    apply_reset("mid-read");
    run_block(1056, 1, -1, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
